branch_pred_pc_sel: RTL

- Parametrised successor to the X-stage PC select logic; adds dynamic branch prediction.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters.
- ID stage: predicts conditional branches and steers fetch to the ID-computed target on jal or predicted-taken.
- X stage: resolves branches and jalr against BrEq/BrLt and the carried prediction, emits redirect/recovery selects, and trains the BHT.

---
 rtl/branch_pred_pc_sel.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_pred_pc_sel.sv
// PC select with bimodal branch prediction: ID-stage predict/steer, X-stage resolve/recover/train.
// Optional performance counters are compiled in when BP_PERF_CNT_EN is defined.
module branch_pred_pc_sel #(
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int PRED_MODE = 1,
  parameter int CNT_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_pc,
  input  logic [6:0]      id_opcode,
  output logic            id_pred_taken,
  input  logic            x_valid,
  input  logic [PC_W-1:0] x_pc,
  input  logic [6:0]      x_opcode,
  input  logic [2:0]      x_func3,
  input  logic            x_pred_taken,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic [1:0]      PCSel,
  output logic            x_redirect,
  output logic            mispredict
`ifdef BP_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SEL_PC4   = 2'b00;
  localparam logic [1:0] SEL_ID    = 2'b01;
  localparam logic [1:0] SEL_X     = 2'b10;
  localparam logic [1:0] SEL_XPC4  = 2'b11;

  // 2-bit saturating counter step: taken moves toward 11, not-taken toward 00.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] nxt;
    nxt = cnt;
    if (up) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       rd_cnt;
  logic             id_is_br_op;
  logic             x_is_br_op;
  logic             func3_legal;
  logic             taken;
  logic             is_br;
  logic             is_jalr;
  logic             train_en;
  logic             unused_pc_bits;

  assign rd_idx = id_pc[IDX_W+1:2];
  assign wr_idx = x_pc[IDX_W+1:2];

  assign unused_pc_bits = ^{id_pc, x_pc};

  assign id_is_br_op = (id_opcode == OPC_BRANCH);
  assign x_is_br_op  = (x_opcode == OPC_BRANCH);
  assign func3_legal = (x_func3 != 3'b010) && (x_func3 != 3'b011);

  always_comb begin
    taken = 1'b0;
    case (x_func3)
      F3_BEQ:           taken = BrEq;
      F3_BNE:           taken = ~BrEq;
      F3_BLT, F3_BLTU:  taken = BrLt;
      F3_BGE, F3_BGEU:  taken = ~BrLt;
      default:          taken = 1'b0;
    endcase
  end

  // X-stage classification; a bubble (x_valid low) silences everything downstream.
  assign is_br   = x_valid & x_is_br_op & func3_legal;
  assign is_jalr = x_valid & (x_opcode == OPC_JALR) & (x_func3 == 3'b000);

  assign mispredict = is_br & (taken ^ x_pred_taken);
  assign x_redirect = is_jalr | mispredict;
  assign train_en   = is_br & ~stall;

  generate
    if (PRED_MODE != 0) begin : g_bimodal
      logic [1:0] bht [BHT_DEPTH];

      // Read is the pre-edge value even when X writes the same entry this cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (train_en) begin
          bht[wr_idx] <= sat_update(bht[wr_idx], taken);
        end
      end

      assign rd_cnt        = bht[rd_idx];
      assign id_pred_taken = id_valid & id_is_br_op & rd_cnt[1];
    end else begin : g_static
      assign rd_cnt        = 2'b01;
      assign id_pred_taken = 1'b0;
    end
  endgenerate

  // X recovery always outranks the ID steer, whose instruction is wrong-path then.
  always_comb begin
    PCSel = SEL_PC4;
    if (is_jalr || (is_br && taken && !x_pred_taken))
      PCSel = SEL_X;
    else if (is_br && !taken && x_pred_taken)
      PCSel = SEL_XPC4;
    else if (id_valid && ((id_opcode == OPC_JAL) || id_pred_taken))
      PCSel = SEL_ID;
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (!stall) begin
      if (is_br)      br_cnt      <= br_cnt + 1'b1;
      if (mispredict) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
`endif

endmodule
